// File: rtl/spi_mem_ctrl.sv
// Command sequencer behind the SPI slave: decodes 10-bit frames, owns the byte memory,
// and hands read bytes back to the slave for serialization onto MISO.
`timescale 1ns/1ps

module spi_mem_ctrl #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8,
  parameter int TX_HOLD   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       busy,
  output logic       cmd_err,
  output logic [7:0] err_cnt
);

  localparam int CNT_W = (TX_HOLD > 1) ? $clog2(TX_HOLD) : 1;

  typedef enum logic [1:0] {IDLE, RD_FETCH, RD_SEND} state_t;

  state_t               state;
  logic [7:0]           mem [MEM_DEPTH];
  logic [ADDR_SIZE-1:0] wr_addr;
  logic [ADDR_SIZE-1:0] rd_addr;
  logic                 wr_armed;
  logic                 rd_armed;
  logic [7:0]           rd_q;
  logic [CNT_W-1:0]     hold_cnt;

  logic [1:0] cmd;
  logic [7:0] payload;
  logic       reject;
  logic       mem_we;

  assign cmd     = rx_data[9:8];
  assign payload = rx_data[7:0];

  // Anything arriving outside IDLE, or a data command before its pointer is armed, is refused.
  always_comb begin
    reject = 1'b0;
    if (rx_valid) begin
      if (state != IDLE)
        reject = 1'b1;
      else if (cmd == 2'b01 && !wr_armed)
        reject = 1'b1;
      else if (cmd == 2'b11 && !rd_armed)
        reject = 1'b1;
    end
  end

  assign mem_we = !rst && (state == IDLE) && rx_valid && (cmd == 2'b01) && wr_armed;

  // Kept out of the reset block so memory contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we)
      mem[wr_addr] <= payload;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      cmd_err  <= 1'b0;
      err_cnt  <= 8'h00;
      wr_addr  <= '0;
      rd_addr  <= '0;
      wr_armed <= 1'b0;
      rd_armed <= 1'b0;
      rd_q     <= 8'h00;
      hold_cnt <= '0;
    end else begin
      cmd_err <= reject;
      if (reject && err_cnt != 8'hFF)
        err_cnt <= err_cnt + 8'd1;

      case (state)
        IDLE: begin
          if (rx_valid && !reject) begin
            case (cmd)
              2'b00: begin
                wr_addr  <= payload[ADDR_SIZE-1:0];
                wr_armed <= 1'b1;
              end
              2'b01: wr_addr <= wr_addr + ADDR_SIZE'(1);
              2'b10: begin
                rd_addr  <= payload[ADDR_SIZE-1:0];
                rd_armed <= 1'b1;
              end
              2'b11: begin
                state <= RD_FETCH;
                busy  <= 1'b1;
              end
            endcase
          end
        end

        // tx_data is loaded alongside rd_q so the byte is on the wire in the first send cycle.
        RD_FETCH: begin
          rd_q     <= mem[rd_addr];
          tx_data  <= mem[rd_addr];
          tx_valid <= 1'b1;
          hold_cnt <= '0;
          state    <= RD_SEND;
        end

        RD_SEND: begin
          tx_data <= rd_q;
          if (hold_cnt == CNT_W'(TX_HOLD - 1)) begin
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            rd_addr  <= rd_addr + ADDR_SIZE'(1);
            state    <= IDLE;
          end else begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Self-checking bench for spi_mem_ctrl: scenario tasks drive frames, a scoreboard queue
// holds the bytes each read must return and a negedge monitor pops and checks them.
`timescale 1ns/1ps

module tb_spi_mem_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       busy;
  logic       cmd_err;
  logic [7:0] err_cnt;

  int checks   = 0;
  int failures = 0;
  int exp_err  = 0;

  logic [7:0] exp_q[$];
  logic       in_run = 1'b0;
  int         run_len = 0;
  logic [7:0] run_data;
  logic [7:0] sb_exp;

  spi_mem_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8), .TX_HOLD(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .busy     (busy),
    .cmd_err  (cmd_err),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: each tx_valid run must match the next queued byte, stay stable, and last 8 cycles.
  always @(negedge clk) begin
    if (rst) begin
      in_run = 1'b0;
    end else if (tx_valid && !in_run) begin
      in_run   = 1'b1;
      run_len  = 1;
      run_data = tx_data;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL sb_unexpected: tx_valid with tx_data=%h, want no read pending", tx_data);
      end else begin
        sb_exp = exp_q.pop_front();
        if (tx_data !== sb_exp) begin
          failures++;
          $display("[TB] FAIL sb_data: got %h want %h", tx_data, sb_exp);
        end
      end
    end else if (tx_valid) begin
      run_len++;
      checks++;
      if (tx_data !== run_data) begin
        failures++;
        $display("[TB] FAIL sb_stable: got %h want %h", tx_data, run_data);
      end
    end else if (in_run) begin
      in_run = 1'b0;
      checks++;
      if (run_len != 8) begin
        failures++;
        $display("[TB] FAIL sb_len: got %0d want 8", run_len);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds the frame for one cycle; returns at the start of the following cycle.
  task automatic send_frame(input logic [1:0] cmd, input logic [7:0] payload);
    rx_data  = {cmd, payload};
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] exp_byte, input int drop_at);
    exp_q.push_back(exp_byte);
    send_frame(2'b11, 8'h00);
    for (int k = 1; k <= 10; k++) begin
      checks++;
      if (busy !== (k <= 9)) begin
        failures++;
        $display("[TB] FAIL rd_busy k=%0d: got %b want %b", k, busy, (k <= 9));
      end
      checks++;
      if (tx_valid !== (k >= 2 && k <= 9)) begin
        failures++;
        $display("[TB] FAIL rd_tx_valid k=%0d: got %b want %b", k, tx_valid, (k >= 2 && k <= 9));
      end
      checks++;
      if (cmd_err !== (drop_at > 0 && k == drop_at + 1)) begin
        failures++;
        $display("[TB] FAIL rd_cmd_err k=%0d: got %b want %b", k, cmd_err, (drop_at > 0 && k == drop_at + 1));
      end
      if (k == drop_at) begin
        rx_data  = {2'b00, 8'h05};
        rx_valid = 1'b1;
        exp_err  = (exp_err < 255) ? exp_err + 1 : 255;
      end else begin
        rx_valid = 1'b0;
      end
      tick();
    end
    rx_valid = 1'b0;
    checks++;
    if (err_cnt !== 8'(exp_err)) begin
      failures++;
      $display("[TB] FAIL rd_err_cnt: got %0d want %0d", err_cnt, exp_err);
    end
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 10'h000;
    tick();
    tick();
    checks++;
    if (tx_data !== 8'h00) begin failures++; $display("[TB] FAIL rst_tx_data: got %h want 00", tx_data); end
    checks++;
    if (tx_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_tx_valid: got %b want 0", tx_valid); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL rst_busy: got %b want 0", busy); end
    checks++;
    if (cmd_err !== 1'b0) begin failures++; $display("[TB] FAIL rst_cmd_err: got %b want 0", cmd_err); end
    checks++;
    if (err_cnt !== 8'h00) begin failures++; $display("[TB] FAIL rst_err_cnt: got %0d want 0", err_cnt); end
    rst     = 1'b0;
    exp_err = 0;
  endtask

  task automatic test_unarmed_read();
    send_frame(2'b11, 8'h00);
    exp_err = exp_err + 1;
    checks++;
    if (cmd_err !== 1'b1) begin failures++; $display("[TB] FAIL unarmed_cmd_err: got %b want 1", cmd_err); end
    checks++;
    if (err_cnt !== 8'(exp_err)) begin failures++; $display("[TB] FAIL unarmed_err_cnt: got %0d want %0d", err_cnt, exp_err); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL unarmed_busy: got %b want 0", busy); end
    tick();
    checks++;
    if (cmd_err !== 1'b0) begin failures++; $display("[TB] FAIL unarmed_cmd_err_fall: got %b want 0", cmd_err); end
    repeat (12) tick();
  endtask

  task automatic test_write_read();
    send_frame(2'b00, 8'h10);
    send_frame(2'b01, 8'hA5);
    send_frame(2'b01, 8'h3C);
    send_frame(2'b10, 8'h10);
    checks++;
    if (cmd_err !== 1'b0) begin failures++; $display("[TB] FAIL wr_cmd_err: got %b want 0", cmd_err); end
    do_read(8'hA5, 0);
    do_read(8'h3C, 0);
  endtask

  task automatic test_wrap();
    send_frame(2'b00, 8'hFF);
    send_frame(2'b01, 8'h11);
    send_frame(2'b01, 8'h22);
    send_frame(2'b10, 8'h00);
    do_read(8'h22, 0);
  endtask

  // wr_addr sits at 0x01 here; a wrongly accepted 00_05 would move the 0x77 write to 0x05.
  task automatic test_drop_busy();
    send_frame(2'b10, 8'h10);
    do_read(8'hA5, 4);
    send_frame(2'b01, 8'h77);
    send_frame(2'b10, 8'h01);
    do_read(8'h77, 0);
  endtask

  task automatic test_reset_mid_read();
    send_frame(2'b10, 8'h10);
    exp_q.push_back(8'hA5);
    send_frame(2'b11, 8'h00);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    checks++;
    if (tx_valid !== 1'b0) begin failures++; $display("[TB] FAIL midrst_tx_valid: got %b want 0", tx_valid); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL midrst_busy: got %b want 0", busy); end
    checks++;
    if (err_cnt !== 8'h00) begin failures++; $display("[TB] FAIL midrst_err_cnt: got %0d want 0", err_cnt); end
    checks++;
    if (tx_data !== 8'h00) begin failures++; $display("[TB] FAIL midrst_tx_data: got %h want 00", tx_data); end
    rst     = 1'b0;
    exp_err = 0;
    send_frame(2'b11, 8'h00);
    exp_err = 1;
    checks++;
    if (cmd_err !== 1'b1) begin failures++; $display("[TB] FAIL midrst_rearm_cmd_err: got %b want 1", cmd_err); end
    checks++;
    if (err_cnt !== 8'(exp_err)) begin failures++; $display("[TB] FAIL midrst_rearm_err_cnt: got %0d want %0d", err_cnt, exp_err); end
    repeat (12) tick();
    send_frame(2'b10, 8'h10);
    do_read(8'hA5, 0);
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 300; i++) begin
      send_frame(2'b01, 8'(i));
      exp_err = (exp_err < 255) ? exp_err + 1 : 255;
      checks++;
      if (cmd_err !== 1'b1) begin failures++; $display("[TB] FAIL sat_cmd_err i=%0d: got %b want 1", i, cmd_err); end
      checks++;
      if (err_cnt !== 8'(exp_err)) begin failures++; $display("[TB] FAIL sat_err_cnt i=%0d: got %0d want %0d", i, err_cnt, exp_err); end
      tick();
      checks++;
      if (cmd_err !== 1'b0) begin failures++; $display("[TB] FAIL sat_cmd_err_fall i=%0d: got %b want 0", i, cmd_err); end
    end
  endtask

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 10'h000;
    test_reset();
    test_unarmed_read();
    test_write_read();
    test_wrap();
    test_drop_busy();
    test_reset_mid_read();
    test_saturation();
    repeat (3) tick();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL sb_leftover: got %0d pending reads want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_mem_ctrl.md
Name: spi_mem_ctrl

Overview:
Command sequencer behind the SPI slave. It decodes each 10-bit frame that the slave delivers on rx_data/rx_valid, holds the write and read address pointers, and owns a single-port byte memory. It returns read bytes to the slave on tx_data/tx_valid for serialization onto MISO. Sequencing errors are flagged and counted.

Parameters:
MEM_DEPTH, 256, number of bytes in the internal memory
ADDR_SIZE, 8, address width; MEM_DEPTH = 2**ADDR_SIZE
TX_HOLD, 8, cycles tx_valid is held per read byte (one per serialized MISO bit)

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst  input  1  synchronous reset, active-high
rx_data  input  10  frame from SPI slave; [9:8] = command, [7:0] = payload
rx_valid  input  1  one-cycle strobe; rx_data is valid in that cycle
tx_data  output  8  read byte to the SPI slave
tx_valid  output  1  high while tx_data is to be shifted out
busy  output  1  high in RD_FETCH and RD_SEND
cmd_err  output  1  one-cycle pulse on any rejected frame
err_cnt  output  8  count of rejected frames, saturates at 255

Behaviour:
- Reset (rst=1 at a clock edge), from any state including mid-read:
  - state=IDLE.
  - tx_data=0, tx_valid=0, busy=0, cmd_err=0, err_cnt=0.
  - wr_addr=0, rd_addr=0, wr_armed=0, rd_armed=0.
  - Memory contents are NOT cleared.
- States: IDLE, RD_FETCH, RD_SEND.
- Frames are decoded only in IDLE when rx_valid=1. Commands:
  - 00 (set write address): wr_addr<=payload, wr_armed<=1.
  - 01 (write data):
    - If wr_armed: mem[wr_addr]<=payload on the same edge, and wr_addr<=wr_addr+1. The pointer wraps MEM_DEPTH-1 -> 0 and wr_armed stays 1.
    - Else: reject.
  - 10 (set read address): rd_addr<=payload, rd_armed<=1.
  - 11 (read data):
    - If rd_armed: go to RD_FETCH.
    - Else: reject. No tx_valid is produced.
- RD_FETCH (1 cycle): registered read, rd_q<=mem[rd_addr]. Then go to RD_SEND.
- RD_SEND:
  - tx_data<=rd_q and tx_valid=1 for exactly TX_HOLD consecutive cycles, then tx_valid<=0 and state<=IDLE.
  - On exit: rd_addr<=rd_addr+1 (wraps), rd_armed stays 1.
  - tx_data holds its last value after tx_valid falls.
- Latency: read-data frame at cycle N -> tx_valid high in cycles N+2 .. N+1+TX_HOLD. busy=1 in cycles N+1 .. N+1+TX_HOLD.
- rx_valid while busy=1: frame dropped and rejected; the read in progress continues unaffected.
- Reject means:
  - cmd_err=1 for the following cycle.
  - err_cnt<=err_cnt+1 unless it is already 255.
  - No pointer, flag or memory change.
- Read-after-write: a read of an address written on an earlier edge returns the new data.
- wr_addr and rd_addr are independent. Writing while rd_armed does not disturb rd_addr.

Test Plan:
- Reset, then frame 11 (read data) -> no tx_valid; cmd_err pulses once; err_cnt=1.
- Frames 00_0x10, 01_0xA5, 01_0x3C, then 10_0x10, 11_xx, 11_xx -> two reads:
  - First: tx_data=0xA5, tx_valid high 8 cycles starting 2 cycles after the first 11 strobe.
  - Second: tx_data=0x3C.
- Frames 00_0xFF, 01_0x11, 01_0x22, 10_0x00, 11 -> tx_data=0x22, confirming wr_addr wrapped 0xFF->0x00.
- Issue 11 with rd_armed, then strobe rx_valid with 00_0x05 during RD_SEND:
  - Frame dropped; cmd_err pulses; err_cnt increments.
  - tx_valid still lasts 8 cycles; wr_addr unchanged.
- Assert rst during RD_SEND -> next cycle tx_valid=0, busy=0, err_cnt=0; the next 11 frame is rejected (rd_armed cleared).
- Issue 300 unarmed 01 frames -> err_cnt saturates at 255; cmd_err pulses for each frame.
